// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single write port of the 32x32 general register file,
// with a pending-write scoreboard that stalls decode on operand hazards.
module regfile_write_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_dst,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      pend_set_en,
  input  logic [ADDR_W-1:0]         pend_set_dst,
  input  logic [ADDR_W-1:0]         rd_addr_a,
  input  logic [ADDR_W-1:0]         rd_addr_b,
  output logic                      stall,
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         write_dst,
  output logic [DATA_W-1:0]         write_data,
  output logic [31:0]               busy_mask
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic              reg_write_q;
  logic [ADDR_W-1:0] write_dst_q;
  logic [DATA_W-1:0] write_data_q;
  logic [31:0]       busy_q, busy_d;

  logic              grant_found;
  logic [PtrW-1:0]   grant_idx;
  logic [ADDR_W-1:0] grant_dst;
  logic [DATA_W-1:0] grant_data;

  // Search starts at the pointer and wraps; the first valid source wins.
  always_comb begin : arb
    int unsigned idx;
    logic [PtrW-1:0] idx_w;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_w       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      idx_w = PtrW'(idx);
      if (!grant_found && req_valid[idx_w]) begin
        grant_found = 1'b1;
        grant_idx   = idx_w;
      end
    end
  end

  assign grant_dst  = req_dst[grant_idx*ADDR_W +: ADDR_W];
  assign grant_data = req_data[grant_idx*DATA_W +: DATA_W];

  always_comb begin
    req_ready = '0;
    if (grant_found && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_found) begin
      ptr_d = (grant_idx == PtrW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Set is applied after clear so a newer producer of the same register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (grant_found) begin
      busy_d[grant_dst] = 1'b0;
    end
    if (pend_set_en && (pend_set_dst != '0)) begin
      busy_d[pend_set_dst] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      reg_write_q  <= 1'b0;
      write_dst_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      if (grant_found) begin
        write_dst_q  <= grant_dst;
        write_data_q <= grant_data;
        reg_write_q  <= (grant_dst != '0);
      end else begin
        reg_write_q  <= 1'b0;
      end
    end
  end

  assign stall = ((rd_addr_a != '0) && busy_q[rd_addr_a]) ||
                 ((rd_addr_b != '0) && busy_q[rd_addr_b]);

  assign reg_write  = reg_write_q;
  assign write_dst  = write_dst_q;
  assign write_data = write_data_q;
  assign busy_mask  = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a negedge-written register file model.
module tb_regfile_write_arbiter;

  localparam int unsigned N_REQ  = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_dst;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    pend_set_en;
  logic [ADDR_W-1:0]       pend_set_dst;
  logic [ADDR_W-1:0]       rd_addr_a;
  logic [ADDR_W-1:0]       rd_addr_b;
  logic                    stall;
  logic                    reg_write;
  logic [ADDR_W-1:0]       write_dst;
  logic [DATA_W-1:0]       write_data;
  logic [31:0]             busy_mask;

  logic [DATA_W-1:0] rf [32];

  int pass_cnt;
  int total_cnt;

  regfile_write_arbiter #(
    .N_REQ (N_REQ),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_dst     (req_dst),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .pend_set_en (pend_set_en),
    .pend_set_dst(pend_set_dst),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .stall       (stall),
    .reg_write   (reg_write),
    .write_dst   (write_dst),
    .write_data  (write_data),
    .busy_mask   (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file samples the registered write on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (reg_write) begin
      rf[write_dst] <= write_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [ADDR_W-1:0] d,
                         input logic [DATA_W-1:0] data);
    req_valid[i]               = v;
    req_dst[i*ADDR_W +: ADDR_W] = d;
    req_data[i*DATA_W +: DATA_W] = data;
  endtask

  task automatic test_reset;
    total_cnt++;
    if (reg_write !== 1'b0) $display("FAIL reset_reg_write: got %b want 0", reg_write);
    else pass_cnt++;
    total_cnt++;
    if (busy_mask !== 32'h0) $display("FAIL reset_busy: got %h want 0", busy_mask);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", req_ready);
    else pass_cnt++;

    pend_set_en  = 1'b1;
    pend_set_dst = 5'd5;
    set_src(1, 1'b1, 5'd8, 32'h1234);
    #1;
    total_cnt++;
    if (req_ready !== 3'b010) $display("FAIL pre_rst_ready: got %b want 010", req_ready);
    else pass_cnt++;
    tick;
    pend_set_en = 1'b0;
    // Mid-stream asynchronous reset with source 1 still requesting.
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({reg_write, busy_mask, req_ready} !== {1'b0, 32'h0, 3'b000})
      $display("FAIL midrst_state: got rw=%b busy=%h rdy=%b want 0/0/000",
               reg_write, busy_mask, req_ready);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 3'b010) $display("FAIL post_rst_ready: got %b want 010", req_ready);
    else pass_cnt++;
    tick;
    set_src(1, 1'b0, 5'd0, 32'h0);
    total_cnt++;
    if ({reg_write, write_dst, write_data} !== {1'b1, 5'd8, 32'h1234})
      $display("FAIL post_rst_write: got rw=%b dst=%0d data=%h want 1/8/1234",
               reg_write, write_dst, write_data);
    else pass_cnt++;
  endtask

  task automatic test_rotation;
    logic [2:0]        exp_rdy [4];
    logic [ADDR_W-1:0] exp_dst [4];
    exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100; exp_rdy[3] = 3'b001;
    exp_dst[0] = 5'd9;   exp_dst[1] = 5'd10;  exp_dst[2] = 5'd11;  exp_dst[3] = 5'd9;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    set_src(0, 1'b1, 5'd9,  32'hA0);
    set_src(1, 1'b1, 5'd10, 32'hA1);
    set_src(2, 1'b1, 5'd11, 32'hA2);
    for (int k = 0; k < 4; k++) begin
      #1;
      total_cnt++;
      if (req_ready !== exp_rdy[k])
        $display("FAIL rot_ready[%0d]: got %b want %b", k, req_ready, exp_rdy[k]);
      else pass_cnt++;
      tick;
      total_cnt++;
      if ({reg_write, write_dst} !== {1'b1, exp_dst[k]})
        $display("FAIL rot_dst[%0d]: got rw=%b dst=%0d want 1/%0d",
                 k, reg_write, write_dst, exp_dst[k]);
      else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) set_src(i, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_zero_reg;
    set_src(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    total_cnt++;
    if (req_ready !== 3'b001) $display("FAIL zero_ready: got %b want 001", req_ready);
    else pass_cnt++;
    tick;
    set_src(0, 1'b0, 5'd0, 32'h0);
    total_cnt++;
    if (reg_write !== 1'b0) $display("FAIL zero_reg_write: got %b want 0", reg_write);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (rf[0] !== 32'h0) $display("FAIL zero_rf0: got %h want 0", rf[0]);
    else pass_cnt++;
    tick;
  endtask

  task automatic test_scoreboard;
    pend_set_en  = 1'b1;
    pend_set_dst = 5'd9;
    tick;
    pend_set_en = 1'b0;
    rd_addr_a   = 5'd9;
    #1;
    total_cnt++;
    if ({stall, busy_mask} !== {1'b1, 32'h0000_0200})
      $display("FAIL sb_pending: got stall=%b busy=%h want 1/00000200", stall, busy_mask);
    else pass_cnt++;
    set_src(2, 1'b1, 5'd9, 32'h99);
    #1;
    total_cnt++;
    if ({req_ready, stall} !== {3'b100, 1'b1})
      $display("FAIL sb_grant_cycle: got rdy=%b stall=%b want 100/1", req_ready, stall);
    else pass_cnt++;
    tick;
    set_src(2, 1'b0, 5'd0, 32'h0);
    total_cnt++;
    if ({stall, busy_mask, reg_write, write_dst} !== {1'b0, 32'h0, 1'b1, 5'd9})
      $display("FAIL sb_cleared: got stall=%b busy=%h rw=%b dst=%0d want 0/0/1/9",
               stall, busy_mask, reg_write, write_dst);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (rf[9] !== 32'h99) $display("FAIL sb_rf9: got %h want 00000099", rf[9]);
    else pass_cnt++;
    tick;
    rd_addr_a = 5'd0;
  endtask

  task automatic test_collision;
    pend_set_en  = 1'b1;
    pend_set_dst = 5'd10;
    tick;
    set_src(0, 1'b1, 5'd10, 32'h10);
    rd_addr_b = 5'd10;
    #1;
    total_cnt++;
    if ({req_ready, stall} !== {3'b001, 1'b1})
      $display("FAIL col_grant: got rdy=%b stall=%b want 001/1", req_ready, stall);
    else pass_cnt++;
    tick;
    set_src(0, 1'b0, 5'd0, 32'h0);
    pend_set_en = 1'b0;
    #1;
    total_cnt++;
    if ({busy_mask, stall} !== {32'h0000_0400, 1'b1})
      $display("FAIL col_set_wins: got busy=%h stall=%b want 00000400/1", busy_mask, stall);
    else pass_cnt++;
    rd_addr_b = 5'd0;
  endtask

  task automatic test_idle_hold;
    set_src(1, 1'b1, 5'd12, 32'hC0DE);
    #1;
    total_cnt++;
    if (req_ready !== 3'b010) $display("FAIL idle_first_ready: got %b want 010", req_ready);
    else pass_cnt++;
    tick;
    set_src(1, 1'b0, 5'd0, 32'h0);
    total_cnt++;
    if ({reg_write, write_dst, busy_mask} !== {1'b1, 5'd12, 32'h0000_0400})
      $display("FAIL idle_write12: got rw=%b dst=%0d busy=%h want 1/12/00000400",
               reg_write, write_dst, busy_mask);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      tick;
      total_cnt++;
      if ({reg_write, write_dst, write_data} !== {1'b0, 5'd12, 32'hC0DE})
        $display("FAIL idle_hold[%0d]: got rw=%b dst=%0d data=%h want 0/12/0000c0de",
                 k, reg_write, write_dst, write_data);
      else pass_cnt++;
    end
    set_src(0, 1'b1, 5'd1, 32'h1);
    set_src(2, 1'b1, 5'd2, 32'h2);
    #1;
    total_cnt++;
    if (req_ready !== 3'b100) $display("FAIL idle_ptr_held: got %b want 100", req_ready);
    else pass_cnt++;
    tick;
    set_src(2, 1'b0, 5'd0, 32'h0);
    #1;
    total_cnt++;
    if ({req_ready, write_dst} !== {3'b001, 5'd2})
      $display("FAIL idle_next: got rdy=%b dst=%0d want 001/2", req_ready, write_dst);
    else pass_cnt++;
    tick;
    set_src(0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    rst          = 1'b1;
    req_valid    = '0;
    req_dst      = '0;
    req_data     = '0;
    pend_set_en  = 1'b0;
    pend_set_dst = '0;
    rd_addr_a    = '0;
    rd_addr_b    = '0;
    repeat (2) tick;
    rst = 1'b0;
    tick;

    test_reset;
    test_rotation;
    test_zero_reg;
    test_scoreboard;
    test_collision;
    test_idle_hold;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 MIPS general register file among N_REQ writeback sources: ALU writeback, load writeback and multiply/divide unit.
- Grants one source per cycle by round-robin and registers the winning write, so the register file samples stable write_dst/write_data/reg_write on the following negedge clk.
- Keeps a pending-write scoreboard and raises stall when either read operand of the instruction in decode has an outstanding write.

Parameters:
N_REQ, 3, number of write requesters (2..8)
DATA_W, 32, register data width
ADDR_W, 5, register index width (32 registers)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  per-source write request
req_dst  input  N_REQ*ADDR_W  per-source destination, source i at bits [i*ADDR_W +: ADDR_W]
req_data  input  N_REQ*DATA_W  per-source write data, same packing
req_ready  output  N_REQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i]
pend_set_en  input  1  decode issued an instruction that will write pend_set_dst
pend_set_dst  input  ADDR_W  destination being marked pending
rd_addr_a  input  ADDR_W  decode read operand A
rd_addr_b  input  ADDR_W  decode read operand B
stall  output  1  operand hazard on pending register
reg_write  output  1  to register file regWrite
write_dst  output  ADDR_W  to register file writeDst
write_data  output  DATA_W  to register file writeData
busy_mask  output  32  scoreboard state, bit r = write to r outstanding

Behaviour:
- Reset (async, rst=1): reg_write=0, write_dst=0, write_data=0, busy_mask=0, round-robin pointer=0, req_ready=0. Reset mid-operation discards any in-flight grant.
- Arbitration: combinational over req_valid. The search starts at pointer p and runs p, p+1, ... wrapping mod N_REQ. The first valid source wins and its req_ready bit is 1. At most one req_ready bit is high. If no source is valid, req_ready=0.
- A source must hold req_valid/req_dst/req_data stable until granted. The arbiter never drops a valid request.
- On a grant to source g at posedge: write_dst<=req_dst[g], write_data<=req_data[g], reg_write<=(req_dst[g]!=0), p<=(g+1) mod N_REQ.
- With no grant: reg_write<=0, write_dst/write_data hold, p holds.
- Latency: request granted in cycle n, so reg_write is high during cycle n+1 and the register file writes on the negedge inside cycle n+1.
- A granted write to register 0 completes the handshake but leaves reg_write=0. Register 0 is never written.
- Fairness: with all sources continuously valid, grants rotate 0,1,2,0,... Each source waits at most N_REQ-1 cycles.
- Scoreboard:
  - On posedge, pend_set_en && pend_set_dst!=0 sets busy_mask[pend_set_dst].
  - A grant to destination d clears busy_mask[d] at the same posedge.
  - Set and clear of the same register in the same cycle: set wins, because a newer producer is outstanding.
  - busy_mask[0] is always 0.
- stall (combinational) = (rd_addr_a!=0 && busy_mask[rd_addr_a]) || (rd_addr_b!=0 && busy_mask[rd_addr_b]).
- The clear from a grant takes effect the cycle after the grant, which is the same cycle the data lands in the register file. stall therefore drops exactly when the register file holds the new value.
- A grant whose destination is not pending leaves busy_mask unchanged. This is not an error.

Test Plan:
1. Reset check: assert rst mid-stream with source 1 valid -> reg_write=0, busy_mask=0, req_ready=0 immediately. After release, source 1 (dst 8, data 0x1234) is granted first because p=0 and source 0 is idle. Next cycle reg_write=1, write_dst=8, write_data=0x1234.
2. Rotation: sources 0,1,2 valid continuously with dst 9,10,11 -> req_ready sequence 001,010,100,001. write_dst sequence 9,10,11,9, delayed one cycle.
3. Zero register: source 0 requests dst 0, data 0xFFFFFFFF -> req_ready[0]=1, next cycle reg_write=0, and the register file value at index 0 stays 0.
4. Scoreboard: pend_set_en with dst 9, then rd_addr_a=9 -> stall=1. Source 2 writes dst 9 -> stall stays 1 through the grant cycle and is 0 in the next cycle.
5. Set/clear collision: grant to dst 10 in the same cycle as pend_set_en dst 10 -> busy_mask[10]=1 afterwards.
6. Idle hold: no requests for 5 cycles after a write to dst 12 -> reg_write=0, write_dst=12, pointer unchanged. The next grant starts its search from the held pointer.
